// File: rtl/fp_pkg.sv
// Shared single-precision field layout and packing helper for the FP datapath.
// The packed word carries the sign in bit 0, exponent above it, fraction on top.
package fp_pkg;
   localparam int SIGN_BIT = 0;
   localparam int EXP_LSB  = 1;
   localparam int EXP_MSB  = 8;
   localparam int FRAC_LSB = 9;
   localparam int FRAC_W   = 23;
   localparam int EXP_MAX  = 255;
   localparam int BIAS     = 127;

   function automatic logic [31:0] pack(input logic [FRAC_W-1:0] frac,
                                        input logic [7:0]        exp,
                                        input logic              sign);
      logic [31:0] w;
      w                    = '0;
      w[31:FRAC_LSB]       = frac;
      w[EXP_MSB:EXP_LSB]   = exp;
      w[SIGN_BIT]          = sign;
      return w;
   endfunction
endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised fraction with guard/sticky, folding the
// carry-out back into the exponent (the fraction wraps to zero on carry).
module fp_round_rne #(
   parameter int EW = 11,
   parameter int FW = 23
) (
   input  logic [FW-1:0]        frac,
   input  logic                 g,
   input  logic                 s,
   input  logic signed [EW-1:0] e_in,
   output logic [FW-1:0]        f,
   output logic signed [EW-1:0] e_out
);
   logic        inc;
   logic [FW:0] sum;

   always_comb begin
      inc   = g & (s | frac[0]);
      sum   = {1'b0, frac} + {{FW{1'b0}}, inc};
      f     = sum[FW-1:0];
      e_out = e_in + {{(EW-1){1'b0}}, sum[FW]};
   end
endmodule

// File: rtl/fpmul_norm_round.sv
// Two-stage normalise / round-and-pack stage behind the FP multiplier core,
// with a single pipe-wide enable driven by downstream back-pressure.
module fpmul_norm_round #(
   parameter int EXP_W = 10,
   parameter int BIAS  = 127
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [47:0]      in_man,
   input  logic             in_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out,
   output logic             ovf,
   output logic             unf
);
   import fp_pkg::*;

   localparam int EW = EXP_W + 1;
   localparam logic signed [EW-1:0] E_OVF  = EW'(2 * BIAS + 1);
   localparam logic signed [EW-1:0] E_ZERO = '0;

   logic                 en;
   logic                 v1_q, v1_d;
   logic                 sign1_q, sign1_d;
   logic                 zero1_q, zero1_d;
   logic [FRAC_W-1:0]    frac1_q, frac1_d;
   logic                 g1_q, g1_d;
   logic                 s1_q, s1_d;
   logic signed [EW-1:0] e1_q, e1_d;
   logic                 out_valid_q, out_valid_d;
   logic [31:0]          out_q, out_d;
   logic                 ovf_q, ovf_d;
   logic                 unf_q, unf_d;
   logic [FRAC_W-1:0]    f_rnd;
   logic signed [EW-1:0] e_rnd;

   assign en = !out_valid_q | out_ready;

   // Stage 1: a product >= 2.0 shifts one place right and bumps the exponent.
   always_comb begin
      v1_d    = v1_q;
      sign1_d = sign1_q;
      zero1_d = zero1_q;
      frac1_d = frac1_q;
      g1_d    = g1_q;
      s1_d    = s1_q;
      e1_d    = e1_q;
      if (en) begin
         v1_d    = in_valid;
         sign1_d = in_sign;
         zero1_d = in_zero | (in_man[47:46] == 2'b00);
         if (in_man[47]) begin
            frac1_d = in_man[46:24];
            g1_d    = in_man[23];
            s1_d    = |in_man[22:0];
         end else begin
            frac1_d = in_man[45:23];
            g1_d    = in_man[22];
            s1_d    = |in_man[21:0];
         end
         e1_d = {in_exp[EXP_W-1], in_exp} + EW'(in_man[47]);
      end
   end

   fp_round_rne #(.EW(EW), .FW(FRAC_W)) u_round (
      .frac  (frac1_q),
      .g     (g1_q),
      .s     (s1_q),
      .e_in  (e1_q),
      .f     (f_rnd),
      .e_out (e_rnd)
   );

   // Stage 2: zero wins over saturation; exponent thresholds are signed.
   always_comb begin
      out_valid_d = out_valid_q;
      out_d       = out_q;
      ovf_d       = ovf_q;
      unf_d       = unf_q;
      if (en) begin
         out_valid_d = v1_q;
         if (v1_q) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
            if (zero1_q) begin
               out_d = pack('0, '0, sign1_q);
            end else if (e_rnd >= E_OVF) begin
               out_d = pack('0, 8'(EXP_MAX), sign1_q);
               ovf_d = 1'b1;
            end else if (e_rnd <= E_ZERO) begin
               out_d = pack('0, '0, sign1_q);
               unf_d = 1'b1;
            end else begin
               out_d = pack(f_rnd, e_rnd[7:0], sign1_q);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q        <= 1'b0;
         sign1_q     <= 1'b0;
         zero1_q     <= 1'b0;
         frac1_q     <= '0;
         g1_q        <= 1'b0;
         s1_q        <= 1'b0;
         e1_q        <= '0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         v1_q        <= v1_d;
         sign1_q     <= sign1_d;
         zero1_q     <= zero1_d;
         frac1_q     <= frac1_d;
         g1_q        <= g1_d;
         s1_q        <= s1_d;
         e1_q        <= e1_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
      end
   end

   assign in_ready  = en;
   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign ovf       = ovf_q;
   assign unf       = unf_q;
endmodule

// File: tb/tb_fpmul_norm_round.sv
// Randomised bench for fpmul_norm_round: an arithmetic reference model feeds a
// scoreboard queue that is checked on every output transfer, plus stall/reset checks.
module tb_fpmul_norm_round;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [9:0]  in_exp;
   logic [47:0] in_man;
   logic        in_zero;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out;
   logic        ovf;
   logic        unf;

   int n_vec = 0;
   int n_err = 0;
   int n_txn = 0;
   bit rand_rdy = 0;
   bit force_stall = 0;

   logic [33:0] sb[$];
   bit          stall_prev = 0;
   bit          rst_prev   = 1;
   logic [33:0] prev_word;

   always #5 clk = ~clk;

   fpmul_norm_round #(.EXP_W(10), .BIAS(127)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_exp    (in_exp),
      .in_man    (in_man),
      .in_zero   (in_zero),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .ovf       (ovf),
      .unf       (unf)
   );

   // Exact-value model: scale the integer product, round on the remainder.
   function automatic logic [33:0] ref_model(input logic sg, input logic [9:0] ex,
                                             input logic [47:0] mn, input logic z);
      longint unsigned m, q, rem, half;
      int sh, e;
      m    = 64'(mn);
      sh   = mn[47] ? 24 : 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      e = int'($signed(ex)) + sh - 23;
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e = e + 1;
      end
      if (z || mn[47:46] == 2'b00) return {2'b00, 23'd0, 8'd0, sg};
      if (e >= 255) return {2'b10, 23'd0, 8'hFF, sg};
      if (e <= 0)   return {2'b01, 23'd0, 8'd0, sg};
      return {2'b00, q[22:0], e[7:0], sg};
   endfunction

   task automatic check34(input string name, input logic [33:0] got, input logic [33:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, got, want);
      end
   endtask

   // Compare process: sampled on the falling edge, ahead of the next rising edge.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         stall_prev = 0;
         rst_prev   = 1;
      end else begin
         if (rst_prev) begin
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
               n_err++;
               $display("FAIL post_reset: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
            end
         end
         if (stall_prev) begin
            n_vec++;
            if (out_valid !== 1'b1 || {ovf, unf, out} !== prev_word) begin
               n_err++;
               $display("FAIL stall_hold: v=%b got %h required %h", out_valid, {ovf, unf, out}, prev_word);
            end
         end
         if (out_valid && !out_ready) begin
            n_vec++;
            if (in_ready !== 1'b0) begin
               n_err++;
               $display("FAIL stall_in_ready: in_ready=%b required 0", in_ready);
            end
         end
         if (out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_output: got %h required none", {ovf, unf, out});
            end else begin
               logic [33:0] want;
               want = sb.pop_front();
               n_txn++;
               $display("txn %0d out=%h ovf=%b unf=%b exp_out=%h exp_ovf=%b exp_unf=%b",
                        n_txn, out, ovf, unf, want[31:0], want[33], want[32]);
               if ({ovf, unf, out} !== want) begin
                  n_err++;
                  $display("FAIL result: got %h required %h", {ovf, unf, out}, want);
               end
            end
         end
         if (in_valid && in_ready) sb.push_back(ref_model(in_sign, in_exp, in_man, in_zero));
         stall_prev = out_valid && !out_ready;
         prev_word  = {ovf, unf, out};
         rst_prev   = 0;
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = force_stall ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
      end
   end

   task automatic send(input logic sg, input logic [9:0] ex, input logic [47:0] mn, input logic z);
      int t;
      t        = 0;
      in_valid = 1'b1;
      in_sign  = sg;
      in_exp   = ex;
      in_man   = mn;
      in_zero  = z;
      @(negedge clk);
      while (!in_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t        = 0;
      rand_rdy = 0;
      while ((sb.size() != 0 || out_valid) && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      n_vec++;
      if (sb.size() != 0 || out_valid) begin
         n_err++;
         $display("FAIL drain_timeout: pending=%0d required 0", sb.size());
      end
   endtask

   task automatic send_random();
      logic [63:0] r;
      logic [47:0] mn;
      logic [9:0]  ex;
      int mode;
      r    = {$urandom, $urandom};
      mn   = r[47:0];
      mode = $urandom_range(0, 9);
      if (mode == 0)      mn[47:46] = 2'b00;
      else if (mode < 5)  mn[47]    = 1'b1;
      else                mn[47:46] = 2'b01;
      if ($urandom_range(0, 3) == 0) begin
         if (mn[47]) mn[23:0] = 24'h800000;
         else        mn[22:0] = 23'h400000;
      end
      case ($urandom_range(0, 3))
         0:       ex = 10'($urandom_range(0, 1023));
         1:       ex = 10'($urandom_range(250, 256));
         2:       ex = 10'($urandom_range(1020, 1026));
         default: ex = 10'($urandom_range(100, 150));
      endcase
      send($urandom_range(0, 1) != 0, ex, mn, $urandom_range(0, 15) == 0);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_sign  = 1'b0;
      in_exp   = '0;
      in_man   = '0;
      in_zero  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check34("reset_out", {ovf, unf, out}, 34'h0);
      check34("reset_hs", {32'd0, out_valid, in_ready}, 34'h1);
      @(posedge clk);
      #1;

      check34("model_1p5sq", ref_model(0, 10'd127, 48'h9000_0000_0000, 0), 34'h0_2000_0100);
      check34("model_tie_even", ref_model(0, 10'd127, 48'h4000_0040_0000, 0), 34'h0_0000_00FE);
      check34("model_tie_up", ref_model(0, 10'd127, 48'h4000_00C0_0000, 0), 34'h0_0000_04FE);
      check34("model_carry", ref_model(0, 10'd127, 48'h7FFF_FFFF_FFFF, 0), 34'h0_0000_0100);
      check34("model_ovf", ref_model(1, 10'd254, 48'h8000_0000_0000, 0), 34'h2_0000_01FF);
      check34("model_unf", ref_model(1, 10'd0, 48'h4000_0000_0000, 0), 34'h1_0000_0001);
      check34("model_zero", ref_model(1, 10'd200, 48'hC123_4567_89AB, 1), 34'h0_0000_0001);
      check34("model_man00", ref_model(1, 10'd130, 48'h2FFF_FFFF_FFFF, 0), 34'h0_0000_0001);

      send(0, 10'd127, 48'h9000_0000_0000, 0);
      send(0, 10'd127, 48'h4000_0040_0000, 0);
      send(0, 10'd127, 48'h4000_00C0_0000, 0);
      send(0, 10'd127, 48'h7FFF_FFFF_FFFF, 0);
      send(1, 10'd254, 48'h8000_0000_0000, 0);
      send(1, 10'd0, 48'h4000_0000_0000, 0);
      send(1, 10'd200, 48'hC123_4567_89AB, 1);
      send(1, 10'd130, 48'h2FFF_FFFF_FFFF, 0);
      drain();

      // Four back-to-back products with a three-cycle downstream stall mid-stream.
      fork
         begin
            for (int i = 0; i < 4; i++) send(i[0], 10'(120 + i), {2'b01, 46'(i * 1234567)}, 0);
         end
         begin
            repeat (2) @(posedge clk);
            force_stall = 1;
            repeat (3) @(posedge clk);
            force_stall = 0;
         end
      join
      drain();

      rand_rdy = 1;
      for (int i = 0; i < 300; i++) begin
         send_random();
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      drain();

      // Reset with two items in flight; the compare process checks the next cycle.
      send(0, 10'd127, 48'h9000_0000_0000, 0);
      send(1, 10'd128, 48'hA000_0000_0000, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || sb.size() != 0) begin
         n_err++;
         $display("FAIL reset_flush: out_valid=%b pending=%0d required 0/0", out_valid, sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
